// File: rtl/store_pkg.sv
// Shared types and helpers for the store narrowing path.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    BEAT0,
    BEAT1,
    DONE
  } state_t;

  // The reserved size encoding is rejected the same way as a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_lane_mux.sv
// Maps latched store data onto the 16-bit write lanes for a given beat.
module store_lane_mux
  import store_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        addr_lsb_i,
  input  logic        beat_i,
  output logic [15:0] wdata_o,
  output logic [1:0]  be_o
);

  always_comb begin
    wdata_o = data_i[15:0];
    be_o    = 2'b11;
    if (size_i == SZ_BYTE) begin
      // Byte is replicated on both lanes; the enable selects the real one.
      wdata_o = {data_i[7:0], data_i[7:0]};
      be_o    = addr_lsb_i ? 2'b10 : 2'b01;
    end else if (beat_i) begin
      wdata_o = data_i[31:16];
    end
  end

endmodule

// File: rtl/store_narrower.sv
// Narrows 32-bit CPU stores onto a 16-bit memory write port, splitting words
// into two little-endian beats and rejecting misaligned requests.
module store_narrower
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  output logic              done,
  output logic              misalign
);

  state_t          state_q, state_d;
  logic [ADDR_W:0] addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [1:0]      size_q, size_d;
  logic            beat;
  logic [15:0]     lane_wdata;
  logic [1:0]      lane_be;

  // Address bits above the halfword port are never forwarded to memory.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    size_d    = size_q;
    req_ready = 1'b0;
    mem_valid = 1'b0;
    beat      = 1'b0;
    done      = 1'b0;
    misalign  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr[ADDR_W:0];
          data_d  = req_data;
          size_d  = req_size;
          state_d = is_misaligned(req_size, req_addr[1:0]) ? ERR : BEAT0;
        end
      end
      ERR: begin
        misalign = 1'b1;
        state_d  = IDLE;
      end
      BEAT0: begin
        mem_valid = 1'b1;
        if (mem_ready) state_d = (size_q == SZ_WORD) ? BEAT1 : DONE;
      end
      BEAT1: begin
        mem_valid = 1'b1;
        beat      = 1'b1;
        if (mem_ready) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  store_lane_mux u_lane_mux (
    .data_i     (data_q),
    .size_i     (size_q),
    .addr_lsb_i (addr_q[0]),
    .beat_i     (beat),
    .wdata_o    (lane_wdata),
    .be_o       (lane_be)
  );

  // Port fields are zeroed outside a beat so idle bus values are deterministic.
  assign mem_addr  = mem_valid ? (addr_q[ADDR_W:1] + ADDR_W'(beat)) : '0;
  assign mem_wdata = mem_valid ? lane_wdata : '0;
  assign mem_be    = mem_valid ? lane_be : '0;

endmodule

// File: tb/tb_store_narrower.sv
// Self-checking bench for store_narrower: directed scenarios plus randomized
// traffic checked every cycle against a transaction-level beat queue model.
module tb_store_narrower;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_data = '0;
  logic [1:0]    req_size = '0;
  logic          mem_valid;
  logic          mem_ready = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [1:0]    mem_be;
  logic          done;
  logic          misalign;

  always #5 clk = ~clk;

  store_narrower #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .done      (done),
    .misalign  (misalign)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected beat as {halfword addr, wdata, be}.
  function automatic logic [33:0] beat_of(input logic [31:0] a, input logic [31:0] d,
                                          input logic [1:0] s, input int idx);
    logic [15:0] ha, wd;
    logic [1:0]  be;
    ha = 16'((a / 2) + idx);
    if (s == 2'd0) begin
      wd = {d[7:0], d[7:0]};
      be = (a % 2 == 1) ? 2'b10 : 2'b01;
    end else begin
      wd = (idx == 1) ? d[31:16] : d[15:0];
      be = 2'b11;
    end
    return {ha, wd, be};
  endfunction

  function automatic bit misal(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0);
  endfunction

  // Reference model: queue of outstanding beats plus completion pulses.
  logic [33:0] q[$];
  bit busy = 0, done_now = 0, mis_now = 0;
  int mdl_good = 0, mdl_mis = 0;
  int done_cnt = 0, mis_cnt = 0;

  always @(negedge clk) begin
    bit wb, nd, nm;
    if (!rst_n) begin
      q.delete();
      busy = 0;
      done_now = 0;
      mis_now = 0;
      chk("rst_mem_addr", mem_addr, 0);
    end
    chk("req_ready", req_ready, !busy);
    chk("mem_valid", mem_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("mem_addr", mem_addr, q[0][33:18]);
      chk("mem_wdata", mem_wdata, q[0][17:2]);
      chk("mem_be", mem_be, q[0][1:0]);
    end else begin
      chk("idle_wdata", mem_wdata, 0);
      chk("idle_be", mem_be, 0);
    end
    chk("done", done, done_now);
    chk("misalign", misalign, mis_now);
    if (rst_n) begin
      if (done) done_cnt++;
      if (misalign) mis_cnt++;
      wb = busy;
      nd = 0;
      nm = 0;
      if (done_now || mis_now) busy = 0;
      if (q.size() != 0 && mem_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) nd = 1;
      end
      if (!wb && req_valid) begin
        busy = 1;
        if (misal(req_addr, req_size)) begin
          nm = 1;
          mdl_mis++;
        end else begin
          q.push_back(beat_of(req_addr, req_data, req_size, 0));
          if (req_size == 2'd2) q.push_back(beat_of(req_addr, req_data, req_size, 1));
          mdl_good++;
        end
      end
      done_now = nd;
      mis_now = nm;
    end
  end

  bit rand_rdy = 0;
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 mem_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns 1 time unit after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      input bit hold);
    int n;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 40);
    if (!req_ready) chk("accept_timeout", req_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) begin
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_data  = $urandom;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int c0, g0, m0, mi0, r;
    logic [31:0] a;
    logic [1:0]  sz;
    bit          hold;

    chk("pin_byte", beat_of(32'h103, 32'hDEADBEEF, 2'd0, 0), {16'h0081, 16'hEFEF, 2'b10});
    chk("pin_word1", beat_of(32'h20, 32'hCAFEF00D, 2'd2, 1), {16'h0011, 16'hCAFE, 2'b11});
    chk("pin_mis", misal(32'h22, 2'd2), 1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    align();

    // Byte store
    send(32'h0000_0103, 32'hDEAD_BEEF, 2'd0, 0);
    @(negedge clk);
    chk("t1_valid", mem_valid, 1);
    chk("t1_addr", mem_addr, 16'h0081);
    chk("t1_wdata", mem_wdata, 16'hEFEF);
    chk("t1_be", mem_be, 2'b10);
    @(negedge clk);
    chk("t1_done", done, 1);
    @(negedge clk);
    chk("t1_ready", req_ready, 1);
    align();

    // Half store
    send(32'h0000_0010, 32'h1234_8001, 2'd1, 0);
    @(negedge clk);
    chk("t2_addr", mem_addr, 16'h0008);
    chk("t2_wdata", mem_wdata, 16'h8001);
    chk("t2_be", mem_be, 2'b11);
    @(negedge clk);
    chk("t2_done", done, 1);
    chk("t2_mis", misalign, 0);
    align();

    // Word store with beat 0 stalled
    mem_ready = 1'b0;
    send(32'h0000_0020, 32'hCAFE_F00D, 2'd2, 0);
    @(negedge clk);
    chk("t3_b0_addr", mem_addr, 16'h0010);
    chk("t3_b0_wdata", mem_wdata, 16'hF00D);
    align();
    @(negedge clk);
    chk("t3_hold_addr", mem_addr, 16'h0010);
    chk("t3_hold_wdata", mem_wdata, 16'hF00D);
    chk("t3_hold_be", mem_be, 2'b11);
    align();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("t3_b0_last", mem_wdata, 16'hF00D);
    @(negedge clk);
    chk("t3_b1_addr", mem_addr, 16'h0011);
    chk("t3_b1_wdata", mem_wdata, 16'hCAFE);
    chk("t3_b1_be", mem_be, 2'b11);
    @(negedge clk);
    chk("t3_done", done, 1);
    align();

    // Misaligned word then misaligned half
    send(32'h0000_0022, 32'h1111_2222, 2'd2, 0);
    @(negedge clk);
    chk("t4w_mis", misalign, 1);
    chk("t4w_valid", mem_valid, 0);
    chk("t4w_ready", req_ready, 0);
    @(negedge clk);
    chk("t4w_ready2", req_ready, 1);
    chk("t4w_done", done, 0);
    align();
    send(32'h0000_0005, 32'h3333_4444, 2'd1, 0);
    @(negedge clk);
    chk("t4h_mis", misalign, 1);
    chk("t4h_valid", mem_valid, 0);
    @(negedge clk);
    chk("t4h_ready2", req_ready, 1);
    chk("t4h_mis_end", misalign, 0);
    align();

    // Back-to-back with req_valid held
    c0 = done_cnt;
    send(32'h0000_0041, 32'hA5A5_5A5A, 2'd0, 1);
    send(32'h0000_0044, 32'h0102_0304, 2'd2, 1);
    send(32'h0000_0046, 32'hFFFF_7777, 2'd1, 0);
    repeat (6) @(negedge clk);
    chk("t5_done_count", done_cnt - c0, 3);
    align();

    // Reset during word beat 1
    c0 = done_cnt;
    send(32'h0000_0080, 32'h1111_2222, 2'd2, 0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", mem_valid, 0);
    chk("t6_async_ready", req_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_no_done", done_cnt - c0, 0);
    align();
    send(32'h0000_0000, 32'h5555_ABCD, 2'd1, 0);
    @(negedge clk);
    chk("t6_addr", mem_addr, 16'h0000);
    chk("t6_wdata", mem_wdata, 16'hABCD);
    chk("t6_be", mem_be, 2'b11);
    @(negedge clk);
    chk("t6_done", done, 1);
    align();

    // Randomized traffic
    c0 = done_cnt;
    g0 = mdl_good;
    m0 = mis_cnt;
    mi0 = mdl_mis;
    rand_rdy = 1;
    repeat (250) begin
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        else if (sz == 2'd2) a[1:0] = 2'b00;
      end
      hold = ($urandom_range(0, 1) == 1);
      send(a, $urandom, sz, hold);
      if (!hold) repeat ($urandom_range(0, 2)) align();
    end
    req_valid = 1'b0;
    rand_rdy = 0;
    @(posedge clk);
    #2 mem_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("rand_done_count", done_cnt - c0, mdl_good - g0);
    chk("rand_mis_count", mis_cnt - m0, mdl_mis - mi0);
    chk("rand_ready", req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_narrower.md
Name: store_narrower

Overview:
- Write-side counterpart of the load/immediate sign-extension path.
- Accepts a 32-bit store request (byte, halfword or word) from the CPU execute stage and narrows it onto a 16-bit-wide data-memory write port.
- Generates lane byte-enables and splits word stores into two little-endian beats.
- Uses a valid/ready handshake on both sides and reports completion and misalignment.

Parameters:
- ADDR_W, 16: width of the halfword-granular memory address port.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: store request valid.
- req_ready, output, 1: block can accept a request.
- req_addr, input, 32: byte address of the store.
- req_data, input, 32: register value to store.
- req_size, input, 2: 00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned).
- mem_valid, output, 1: memory write beat valid.
- mem_ready, input, 1: memory accepts the current beat.
- mem_addr, output, ADDR_W: halfword address, equal to req_addr[ADDR_W:1] (+1 on word beat 1).
- mem_wdata, output, 16: write data lanes.
- mem_be, output, 2: byte enables; bit0 is the low byte, bit1 the high byte.
- done, output, 1: one-cycle pulse when the store fully completes.
- misalign, output, 1: one-cycle pulse when a request is rejected.

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE; req_ready=1; mem_valid=0; mem_addr=0; mem_wdata=0; mem_be=0; done=0; misalign=0; all latched request fields cleared.
- Reset asserted mid-transfer aborts immediately: mem_valid drops asynchronously and no done pulse is issued. Partially written words are not rolled back.
- FSM states:
  - IDLE: req_ready=1.
    - Handshake (req_valid & req_ready) at edge N latches addr, data and size.
    - If misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=11): go to ERR.
    - Otherwise go to BEAT0.
  - ERR: misalign=1 for exactly one cycle, req_ready=0, no memory activity. Return to IDLE.
  - BEAT0: mem_valid=1, req_ready=0. Lane mapping by size:
    - Byte: wdata={d[7:0],d[7:0]}, be = addr[0] ? 10 : 01.
    - Half: wdata=d[15:0], be=11.
    - Word: wdata=d[15:0], be=11, mem_addr=addr>>1.
    - On mem_ready: word goes to BEAT1; byte/half go to DONE.
  - BEAT1 (word only): mem_valid=1, wdata=d[31:16], be=11, mem_addr=(addr>>1)+1, wrapping modulo 2^ADDR_W. On mem_ready go to DONE.
  - DONE: done=1 for one cycle, mem_valid=0, req_ready=0. Return to IDLE.
- While mem_valid=1 and mem_ready=0, mem_addr, mem_wdata and mem_be hold stable. mem_valid never deasserts before a handshake.
- Latency with mem_ready tied to 1, request accepted at edge N:
  - Byte/half: mem_valid high in cycle N+1, done in N+2, req_ready high again in N+3.
  - Word: beats in N+1 and N+2, done in N+3.
  - Throughput: one request per 3 (byte/half) or 4 (word) cycles.
- req_valid asserted while req_ready=0 is ignored. The requester must hold the request until it is accepted.
- req_data and req_addr may change after acceptance; only the latched copies drive the memory port.
- mem_wdata and mem_be are 0 whenever mem_valid=0.

Decomposition:
- Package store_pkg:
  - size_t enum: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - state_t enum: IDLE, ERR, BEAT0, BEAT1, DONE.
  - Function is_misaligned(size, addr[1:0]).
- Sub-module store_lane_mux: combinational; takes latched data, size, addr[0] and a beat index, and produces wdata and be. It is unit-testable on its own.
- The FSM, registers and handshake logic stay in store_narrower.

Test Plan:
- Byte store, addr=0x0000_0103, data=0xDEAD_BEEF, mem_ready=1 → one beat: mem_addr=0x0081, wdata=0xEFEF, be=10; done pulses at N+2.
- Half store, addr=0x0000_0010, data=0x1234_8001 → one beat: mem_addr=0x0008, wdata=0x8001, be=11; done=1, misalign=0.
- Word store, addr=0x0000_0020, data=0xCAFE_F00D, mem_ready low for 2 cycles on beat 0 → beat 0 is held stable (0x0010/0xF00D/11) until ready; then beat 1 is 0x0011/0xCAFE/11; done once.
- Misaligned word, addr=0x0000_0022, and half, addr=0x0000_0005 → misalign pulses one cycle each, mem_valid stays 0, done stays 0, req_ready returns 2 cycles after acceptance.
- Back-to-back requests with req_valid held high (byte, word, half) → each is accepted only when req_ready=1; beat sequence and done count (3) are correct.
- rst_n pulled low during word BEAT1 → mem_valid=0 immediately, no done pulse. After release, a new half store at addr=0x0000_0000 completes normally.
